// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Holds FSM encoding, requester ids and the IO-region address codes.
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_MEM = 1'b0;
    localparam req_id_t REQ_DMA = 1'b1;

    // addr[11:10] region codes; anything but RD is IO space
    localparam logic [1:0] RD = 2'b00;
    localparam logic [1:0] LD = 2'b01;
    localparam logic [1:0] SW = 2'b10;

    function automatic logic is_io(input logic [1:0] region);
        return region != RD;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select with a single-bit pointer.
// The pointer moves to the loser each time a grant is taken.
module rr_arb2
    import dm_arb_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_req0,
    input  logic    i_req1,
    input  logic    i_adv,
    output req_id_t o_win
);

    req_id_t r_ptr;

    always_comb begin
        o_win = REQ_MEM;
        unique case (1'b1)
            (i_req0 & i_req1):  o_win = r_ptr;
            (~i_req0 & i_req1): o_win = REQ_DMA;
            default:            o_win = REQ_MEM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= REQ_MEM;
        end else if (i_adv) begin
            r_ptr <= ~o_win;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates MEM-stage and debug/DMA accesses onto one memory port.
// Each transaction takes IDLE->ACCESS->RESP; DMA writes to IO are blocked.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [2:0]        ctrl0,
    input  logic [2:0]        ctrl1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_ctrl,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              r_state;
    state_t              w_next;
    req_id_t             w_win;
    req_id_t             r_id;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [2:0]          r_ctrl;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic                r_err0;
    logic                r_err1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                w_accept;
    logic                w_deny;
    logic                w_busy;

    assign w_accept = (r_state == IDLE) & (req0 | req1);
    assign w_busy   = (r_state != IDLE);
    assign w_deny   = (r_id == REQ_DMA) & r_we
                    & is_io(r_addr[11:10]);

    rr_arb2 u_rr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_req0 (req0),
        .i_req1 (req1),
        .i_adv  (w_accept),
        .o_win  (w_win)
    );

    always_comb begin
        w_next = IDLE;
        unique case (r_state)
            IDLE:    w_next = w_accept ? ACCESS : IDLE;
            ACCESS:  w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_id    <= REQ_MEM;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ctrl  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_id    <= w_win;
                r_we    <= w_win ? we1 : we0;
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
                r_ctrl  <= w_win ? ctrl1 : ctrl0;
            end
        end
    end

    // memory read data arrives during RESP and is captured at its end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            if (r_state == RESP) begin
                if (r_id == REQ_MEM) begin
                    r_rvalid0 <= 1'b1;
                    r_err0    <= w_deny;
                    if (!r_we) r_rdata0 <= mem_rdata;
                end else begin
                    r_rvalid1 <= 1'b1;
                    r_err1    <= w_deny;
                    if (!r_we) r_rdata1 <= mem_rdata;
                end
            end
        end
    end

    assign gnt0      = (r_state == ACCESS) & (r_id == REQ_MEM);
    assign gnt1      = (r_state == ACCESS) & (r_id == REQ_DMA);
    assign mem_we    = (r_state == ACCESS) & r_we & ~w_deny;
    assign mem_addr  = w_busy ? r_addr : '0;
    assign mem_wdata = w_busy ? r_wdata : '0;
    assign mem_ctrl  = w_busy ? r_ctrl : '0;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;

endmodule
